// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared definitions for the multiply sequencing controller.
//   MUL_OP_W       width of the one-hot multiply op field
//   MUL_OP_*       bit positions inside the op field
//   mulc_state_t   controller states (IDLE, CALC, DONE)
package mul_ctrl_pkg;

   localparam int unsigned MUL_OP_W      = 3;
   localparam int unsigned MUL_OP_MULW   = 2;  // mul.w   : low word, signed
   localparam int unsigned MUL_OP_MULHW  = 1;  // mulh.w  : high word, signed
   localparam int unsigned MUL_OP_MULHWU = 0;  // mulh.wu : high word, unsigned

   typedef enum logic [1:0] {
      MULC_IDLE = 2'd0,
      MULC_CALC = 2'd1,
      MULC_DONE = 2'd2
   } mulc_state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: request / response handshake bundle of the multiply controller.
//   req_valid/req_ready          request handshake
//   req_src1/req_src2            32-bit operands
//   req_op                       one-hot op (see mul_ctrl_pkg)
//   req_tag                      opaque tag, echoed on the response
//   resp_valid/resp_ready        response handshake
//   resp_result/resp_tag         selected product word and its tag
// master: the issuing pipeline stage; slave: mul_ctrl.
interface mul_ctrl_if
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned TAG_W = 5
);

   logic                req_valid;
   logic                req_ready;
   logic [31:0]         req_src1;
   logic [31:0]         req_src2;
   logic [MUL_OP_W-1:0] req_op;
   logic [TAG_W-1:0]    req_tag;
   logic                resp_valid;
   logic                resp_ready;
   logic [31:0]         resp_result;
   logic [TAG_W-1:0]    resp_tag;

   modport master (
      output req_valid, req_src1, req_src2, req_op, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_tag
   );

   modport slave (
      input  req_valid, req_src1, req_src2, req_op, req_tag, resp_ready,
      output req_ready, resp_valid, resp_result, resp_tag
   );

endinterface

// File: rtl/mul_ctrl_mul.sv
// mul_ctrl_mul: combinational 32x32 multiplier of the EXE stage.
//   src1, src2  operands
//   op          one-hot op; priority mul.w > mulh.w > unsigned high word
//   result      selected 32-bit product word
module mul_ctrl_mul
   import mul_ctrl_pkg::*;
(
   input  logic [31:0]         src1,
   input  logic [31:0]         src2,
   input  logic [MUL_OP_W-1:0] op,
   output logic [31:0]         result
);

   logic               signed_mode;
   logic               sel_hi;
   logic signed [32:0] a_ext;
   logic signed [32:0] b_ext;
   logic signed [63:0] prod;

   // Priority decode over the whole op field: any op without bit2/bit1 set
   // (including 000 and bit0-only) falls back to the unsigned high word.
   always_comb begin
      signed_mode = 1'b0;
      sel_hi      = 1'b1;
      casez (op)
         3'b1??: begin
            signed_mode = 1'b1;
            sel_hi      = 1'b0;
         end
         3'b01?: signed_mode = 1'b1;
         default: ;
      endcase
   end

   // One 33x33 signed multiplier covers both signednesses: the extra bit is
   // a sign extension in signed mode and zero otherwise.
   assign a_ext  = {signed_mode & src1[31], src1};
   assign b_ext  = {signed_mode & src2[31], src2};
   assign prod   = 64'(a_ext * b_ext);
   assign result = sel_hi ? prod[63:32] : prod[31:0];

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: multi-cycle sequencing controller for the EXE-stage multiplier.
// Accepts one request, holds the operands in registers for LATENCY cycles so
// the multiplier can be timed as a multicycle path, then captures the result
// and presents it until the consumer takes it.
//   clk     rising-edge clock
//   resetn  synchronous, active-low reset
//   flush   cancels any in-flight operation; blocks acceptance this cycle
//   busy    high whenever the controller is not idle (EXE stall source)
//   bus     request/response handshake bundle (slave side)
// Parameters: LATENCY (1..8) CALC cycles before capture; TAG_W tag width.
module mul_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned TAG_W   = 5
)
(
   input  logic         clk,
   input  logic         resetn,
   input  logic         flush,
   output logic         busy,
   mul_ctrl_if.slave    bus
);

   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   mulc_state_t         state;
   logic [2:0]          cnt;
   logic [31:0]         src1_q;
   logic [31:0]         src2_q;
   logic [MUL_OP_W-1:0] op_q;
   logic [TAG_W-1:0]    tag_q;
   logic                resp_valid_q;
   logic [31:0]         resp_result_q;
   logic [TAG_W-1:0]    resp_tag_q;
   logic                busy_q;
   logic                req_ready;
   logic                accept;
   logic [31:0]         mul_result;

   // Operands come only from the latched registers, never from req_*, so
   // there is no combinational path from the request to the response.
   mul_ctrl_mul u_mul (
      .src1   (src1_q),
      .src2   (src2_q),
      .op     (op_q),
      .result (mul_result)
   );

   // DONE with resp_ready frees the slot this cycle: back-to-back issue.
   assign req_ready = !flush &&
                      ((state == MULC_IDLE) ||
                       ((state == MULC_DONE) && bus.resp_ready));
   assign accept    = bus.req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= MULC_IDLE;
         cnt           <= '0;
         src1_q        <= '0;
         src2_q        <= '0;
         op_q          <= '0;
         tag_q         <= '0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_tag_q    <= '0;
         busy_q        <= 1'b0;
      end else if (flush) begin
         // A DONE handshake coinciding with flush still completes: the
         // consumer has the data and the state lands in IDLE either way.
         state        <= MULC_IDLE;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            MULC_IDLE: begin
               if (accept) begin
                  src1_q <= bus.req_src1;
                  src2_q <= bus.req_src2;
                  op_q   <= bus.req_op;
                  tag_q  <= bus.req_tag;
                  cnt    <= CNT_INIT;
                  state  <= MULC_CALC;
                  busy_q <= 1'b1;
               end
            end
            MULC_CALC: begin
               if (cnt == 3'd0) begin
                  resp_result_q <= mul_result;
                  resp_tag_q    <= tag_q;
                  resp_valid_q  <= 1'b1;
                  state         <= MULC_DONE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            MULC_DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  if (accept) begin
                     src1_q <= bus.req_src1;
                     src2_q <= bus.req_src2;
                     op_q   <= bus.req_op;
                     tag_q  <= bus.req_tag;
                     cnt    <= CNT_INIT;
                     state  <= MULC_CALC;
                  end else begin
                     state  <= MULC_IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end
            default: begin
               state        <= MULC_IDLE;
               resp_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_tag    = resp_tag_q;
   assign busy            = busy_q;

endmodule
